ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Execute-stage multiply/divide unit and owner of the architectural HI/LO register pair.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and writes HI/LO.
- Drives the 64-bit hilo bus that the EX ALU reads for MFHI/MFLO.
- Stalls the pipeline while a multi-cycle operation is in flight.

Parameters:
- HILO_RESET, 64'h0, value loaded into {HI,LO} on reset.
- DIV_ITER, 32, divider iteration count; fixed at 32 for this design.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous reset, active-high
- op_valid  input  1  EX stage holds a valid instruction
- op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- src_a  input  32  rs operand (dividend / multiplicand / MTxx data)
- src_b  input  32  rt operand (divisor / multiplier)
- hold  input  1  EX held by some other stall source this cycle
- flush  input  1  kill EX instruction (exception/ERET)
- stall  output  1  unit requests pipeline stall (combinational)
- hilo  output  64  {HI,LO} register contents

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: {HI,LO}=HILO_RESET; state=IDLE; stall=0; counters and operand registers=0.
- States: IDLE, MUL, DIV, FIX, DONE.
- issue = op_valid & ~flush & state==IDLE & op in {1..4}.
- IDLE:
  - On issue, latch operands and signedness. MULT/MULTU -> MUL. DIV/DIVU -> DIV with count=0.
  - MTHI/MTLO with op_valid & ~flush: write HI or LO at the clock edge, no stall. Repeating while hold is high is allowed (idempotent).
- MUL: 64-bit product registered into {HI,LO} at the end of this cycle, then -> DONE.
  - MULT: signed 32x32. MULTU: unsigned.
- DIV: radix-2 restoring divide on magnitudes (|a|, |b| for DIV; raw for DIVU), one quotient bit per cycle.
  - After 32 iterations (count==31) -> FIX.
- FIX: apply signs and write {HI,LO}, then -> DONE.
  - Quotient is negated if a[31]^b[31]. Remainder takes the sign of a.
  - LO=quotient, HI=remainder.
- DONE: stall=0. The instruction still in EX is ignored (no re-issue).
  - Stay in DONE while hold=1; otherwise -> IDLE.
- stall = issue | state in {MUL, DIV, FIX}.
- Latency, issue cycle = cycle 0:
  - MULT: HI/LO visible cycle 2; stall high cycles 0-1.
  - DIV: HI/LO visible cycle 34; stall high cycles 0-33.
- Divide by zero (b==0), signed or unsigned: normal full latency; result forced to LO=32'hFFFF_FFFF, HI=src_a.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (natural wrap, no exception).
- flush:
  - In any state, returns to IDLE next cycle and aborts any write that would happen that edge; HI/LO keep their prior value.
  - flush in IDLE blocks issue and MTxx writes.
- rst has priority over flush, which has priority over completion/writes.
- hilo is a direct register output. A write at edge N is visible in cycle N+1; no bypass.
- The unit never raises exceptions.

Test Plan:
- Reset, then MULT a=0xFFFFFFFD (-3), b=7 -> stall high exactly 2 cycles; hilo=0xFFFFFFFF_FFFFFFEB in cycle 2. Same operands with MULTU -> hilo=0x00000006_FFFFFFEB.
- DIVU a=100, b=7 -> stall high cycles 0-33; cycle 34 hilo={32'd2, 32'd14}. DIV a=-7, b=2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFD.
- DIV a=0x12345678, b=0 -> 34-cycle stall; HI=0x12345678, LO=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Pre-load HI/LO via MTHI 0xAAAA0000 / MTLO 0x5555. Issue DIV, assert flush in cycle 10 -> stall low in cycle 11; hilo unchanged = {0xAAAA0000, 0x00005555}.
- MULT completes with hold=1 for 3 cycles after DONE -> unit stays DONE, no second write, stall=0. Then back-to-back MULTU 2x3 -> hilo=6 after its own 2-cycle stall.
- MTLO 0x1 issued with hold=1 for 2 cycles -> LO=1, stall never asserted. Assert rst mid-DIV (cycle 5) -> hilo=HILO_RESET and stall=0 next cycle.

Source files
------------

// File: rtl/ex_muldiv.sv
// Execute-stage multiply/divide unit; owns the HI/LO pair.
// Single-cycle multiply, 32-step restoring divide, MTHI/MTLO writes.
module ex_muldiv #(
  parameter logic [63:0] HILO_RESET = 64'h0,
  parameter int          DIV_ITER   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hold,
  input  logic        flush,
  output logic        stall,
  output logic [63:0] hilo
);

  typedef enum logic [2:0] {
    IDLE, MUL, DIV, FIX, DONE
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [4:0] LAST     = 5'(DIV_ITER - 1);

  state_t      state, state_n;
  logic [31:0] hi, lo;
  logic [31:0] a_q, b_q;
  logic [31:0] rem_q, quo_q;
  logic        sgn_q;
  logic [4:0]  cnt_q;

  logic        is_mul, is_div, issue;
  logic        sgn_in;
  logic [31:0] a_mag_in;
  logic        a_neg, b_neg;
  logic [31:0] b_mag;
  logic [63:0] mul_a, mul_b, prod;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] rem_n, quo_n;
  logic [31:0] q_fix, r_fix;

  assign hilo   = {hi, lo};
  assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div = (op == OP_DIV) || (op == OP_DIVU);
  assign issue  = op_valid && !flush && (state == IDLE)
                  && (is_mul || is_div);
  assign stall  = issue || (state == MUL) || (state == DIV)
                  || (state == FIX);

  // Signedness only matters for MULT/DIV; latched at issue.
  assign sgn_in   = (op == OP_MULT) || (op == OP_DIV);
  assign a_mag_in = (op == OP_DIV && src_a[31]) ? -src_a : src_a;

  assign a_neg = sgn_q && a_q[31];
  assign b_neg = sgn_q && b_q[31];
  assign b_mag = b_neg ? -b_q : b_q;

  // Low 64 bits of the extended product equal the signed/unsigned result.
  assign mul_a = {{32{a_neg}}, a_q};
  assign mul_b = {{32{b_neg}}, b_q};
  assign prod  = mul_a * mul_b;

  assign shifted = {rem_q, quo_q[31]};
  assign ge      = shifted >= {1'b0, b_mag};
  assign rem_n   = ge ? 32'(shifted - {1'b0, b_mag}) : shifted[31:0];
  assign quo_n   = {quo_q[30:0], ge};

  assign q_fix = (a_neg ^ b_neg) ? -quo_q : quo_q;
  assign r_fix = a_neg ? -rem_q : rem_q;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (issue) state_n = is_mul ? MUL : DIV;
      MUL:  state_n = DONE;
      DIV:  if (cnt_q == LAST) state_n = FIX;
      FIX:  state_n = DONE;
      DONE: if (!hold) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hi    <= HILO_RESET[63:32];
      lo    <= HILO_RESET[31:0];
      a_q   <= '0;
      b_q   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      sgn_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state <= state_n;
      if (!flush) begin
        unique case (state)
          IDLE: begin
            if (issue) begin
              a_q   <= src_a;
              b_q   <= src_b;
              sgn_q <= sgn_in;
              cnt_q <= '0;
              rem_q <= '0;
              quo_q <= a_mag_in;
            end else if (op_valid && op == OP_MTHI) begin
              hi <= src_a;
            end else if (op_valid && op == OP_MTLO) begin
              lo <= src_a;
            end
          end
          MUL: {hi, lo} <= prod;
          DIV: begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt_q <= cnt_q + 5'd1;
          end
          FIX: begin
            if (b_q == '0) begin
              hi <= a_q;
              lo <= 32'hFFFF_FFFF;
            end else begin
              hi <= r_fix;
              lo <= q_fix;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: latency, results, flush,
// hold, MTxx and mid-operation reset.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic        stall;
  logic [63:0] hilo;

  int tests = 0;
  int fails = 0;
  logic [63:0] sb[$];

  ex_muldiv #(.HILO_RESET(64'h0), .DIV_ITER(32)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
    .src_a(src_a), .src_b(src_b), .hold(hold), .flush(flush),
    .stall(stall), .hilo(hilo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string nm, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input int exp_st, input logic [63:0] exp);
    int n;
    bit done;
    logic [63:0] e;
    sb.push_back(exp);
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    n = 0; done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (stall) begin n++; tick(); end
      else done = 1;
    end
    e = sb.pop_front();
    tests++;
    if (!done || hilo !== e) begin
      fails++;
      $display("FAIL %s hilo got %h want %h", nm, hilo, e);
    end
    tests++;
    if (n !== exp_st) begin
      fails++;
      $display("FAIL %s stall_cycles got %0d want %0d", nm, n, exp_st);
    end
    tick();
    op_valid = 1'b0; op = 3'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (hilo !== 64'h0 || stall !== 1'b0) begin
      fails++;
      $display("FAIL reset hilo=%h stall=%b want 0/0", hilo, stall);
    end
    tick();
  endtask

  task automatic test_mul();
    do_op("mult", 3'd1, 32'hFFFF_FFFD, 32'd7, 2, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op("multu", 3'd2, 32'hFFFF_FFFD, 32'd7, 2, 64'h0000_0006_FFFF_FFEB);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      do_op("multu_rand", 3'd2, a, b, 2, {32'h0, a} * {32'h0, b});
    end
  endtask

  task automatic test_div();
    do_op("divu", 3'd4, 32'd100, 32'd7, 34, {32'd2, 32'd14});
    do_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 34,
          {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_op("div_zero", 3'd3, 32'h1234_5678, 32'd0, 34,
          {32'h1234_5678, 32'hFFFF_FFFF});
    do_op("divu_zero", 3'd4, 32'hCAFE_0001, 32'd0, 34,
          {32'hCAFE_0001, 32'hFFFF_FFFF});
    do_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 34,
          {32'h0, 32'h8000_0000});
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom_range(1, 32'h0001_0000);
      do_op("divu_rand", 3'd4, a, b, 34, {a % b, a / b});
    end
  endtask

  task automatic mtx(input logic [2:0] o, input logic [31:0] d);
    op_valid = 1'b1; op = o; src_a = d;
    tick();
    op_valid = 1'b0; op = 3'd0;
  endtask

  task automatic test_flush();
    logic [63:0] e;
    mtx(3'd5, 32'hAAAA_0000);
    mtx(3'd6, 32'h0000_5555);
    sb.push_back({32'hAAAA_0000, 32'h0000_5555});
    op_valid = 1'b1; op = 3'd3; src_a = 32'd100; src_b = 32'd7;
    repeat (10) tick();
    @(negedge clk);
    tests++;
    if (stall !== 1'b1) begin
      fails++;
      $display("FAIL flush_pre stall got %b want 1", stall);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0; op_valid = 1'b0; op = 3'd0;
    @(negedge clk);
    e = sb.pop_front();
    tests++;
    if (stall !== 1'b0 || hilo !== e) begin
      fails++;
      $display("FAIL flush stall=%b hilo=%h want 0 %h", stall, hilo, e);
    end
    tick();
  endtask

  task automatic test_hold();
    bit done;
    logic [63:0] e;
    sb.push_back(64'd30);
    op_valid = 1'b1; op = 3'd1; src_a = 32'd5; src_b = 32'd6;
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (stall) tick();
      else done = 1;
    end
    e = sb.pop_front();
    tests++;
    if (!done || hilo !== e) begin
      fails++;
      $display("FAIL hold_done hilo got %h want %h", hilo, e);
    end
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      tests++;
      if (stall !== 1'b0 || hilo !== e) begin
        fails++;
        $display("FAIL hold_stay stall=%b hilo=%h want 0 %h",
                 stall, hilo, e);
      end
    end
    hold = 1'b0;
    tick();
    op_valid = 1'b0; op = 3'd0;
    @(negedge clk);
    tests++;
    if (stall !== 1'b0) begin
      fails++;
      $display("FAIL hold_release stall got %b want 0", stall);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_op("b2b_multu", 3'd2, 32'd2, 32'd3, 2, 64'd6);
    do_op("b2b_mult", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 64'd1);
  endtask

  task automatic test_mtlo_hold();
    logic [63:0] e;
    sb.push_back({32'h0, 32'h1});
    op_valid = 1'b1; op = 3'd6; src_a = 32'h1; hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (stall !== 1'b0) begin
        fails++;
        $display("FAIL mtlo_hold stall got %b want 0", stall);
      end
      tick();
    end
    hold = 1'b0; op_valid = 1'b0; op = 3'd0;
    @(negedge clk);
    e = sb.pop_front();
    tests++;
    if (hilo !== e) begin
      fails++;
      $display("FAIL mtlo hilo got %h want %h", hilo, e);
    end
    tick();
  endtask

  task automatic test_reset_mid_div();
    op_valid = 1'b1; op = 3'd4; src_a = 32'd100; src_b = 32'd7;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; op_valid = 1'b0; op = 3'd0;
    @(negedge clk);
    tests++;
    if (hilo !== 64'h0 || stall !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_div hilo=%h stall=%b want 0/0", hilo, stall);
    end
    tick();
  endtask

  initial begin
    #1;
    test_reset();
    test_mul();
    test_div();
    test_flush();
    test_hold();
    test_back_to_back();
    test_mtlo_hold();
    test_reset_mid_div();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
